// File: rtl/fpu_wb_pkg.sv
// Shared types for the FPU writeback result buffer.
// Entry layout, status flag bundle and the NaN-box fill pattern.
package fpu_wb_pkg;

  localparam int unsigned RB_MAX_WIDTH = 64;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic [RB_MAX_WIDTH-1:0] result;
    status_t                 status;
    logic                    is_fp32;
  } rb_entry_t;

  localparam logic [RB_MAX_WIDTH-1:0] NANBOX_FILL = {{(RB_MAX_WIDTH-32){1'b1}}, 32'h0};

endpackage

// File: rtl/fpu_result_buffer.sv
// In-order result queue between the FPU wrapper and core writeback.
// Absorbs unstallable result pulses, NaN-boxes FP32 results and accrues fflags.
module fpu_result_buffer
  import fpu_wb_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter type         TagType  = logic
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             fpu_valid_i,
  input  logic [WIDTH-1:0] fpu_result_i,
  input  logic [4:0]       fpu_status_i,
  input  TagType           fpu_tag_i,
  input  logic             fpu_is_fp32_i,
  output logic             almost_full_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [WIDTH-1:0] wb_result_o,
  output logic [4:0]       wb_status_o,
  output TagType           wb_tag_o,
  output logic [4:0]       fflags_o,
  input  logic             clear_fflags_i,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rb_entry_t          entries_q [DEPTH];
  TagType             tags_q    [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [4:0]         fflags_q, fflags_d;
  logic               overflow_q, overflow_d;

  logic               push, pop, full, write_en;
  rb_entry_t          entry_in;
  rb_entry_t          head;
  logic [RB_MAX_WIDTH-1:0] boxed;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = fpu_valid_i & ~flush_i;
  assign pop      = wb_valid_o & wb_ready_i & ~flush_i;
  // When full, a push only lands if the head leaves in the same cycle.
  assign write_en = push & (~full | pop);

  assign entry_in.result  = RB_MAX_WIDTH'(fpu_result_i);
  assign entry_in.status  = status_t'(fpu_status_i);
  assign entry_in.is_fp32 = fpu_is_fp32_i;

  always_ff @(posedge clk_i) begin
    if (write_en) begin
      entries_q[wr_ptr_q] <= entry_in;
      tags_q[wr_ptr_q]    <= fpu_tag_i;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fflags_d   = fflags_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (write_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({write_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push & full & ~pop) overflow_d = 1'b1;
    end

    // Clear and accrue in the same cycle keep the popped status.
    if (pop)                 fflags_d = (clear_fflags_i ? 5'b0 : fflags_q) | wb_status_o;
    else if (clear_fflags_i) fflags_d = 5'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fflags_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fflags_q   <= fflags_d;
      overflow_q <= overflow_d;
    end
  end

  // Head outputs are gated so an empty (or just reset) buffer shows zeros.
  assign head  = entries_q[rd_ptr_q];
  assign boxed = NANBOX_FILL | {{(RB_MAX_WIDTH-32){1'b0}}, head.result[31:0]};

  assign wb_valid_o    = (count_q != '0);
  assign wb_result_o   = !wb_valid_o    ? '0 :
                         head.is_fp32   ? boxed[WIDTH-1:0] : head.result[WIDTH-1:0];
  assign wb_status_o   = wb_valid_o ? head.status : 5'b0;
  assign wb_tag_o      = wb_valid_o ? tags_q[rd_ptr_q] : '0;
  assign almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
  assign fflags_o      = fflags_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Scoreboard bench for fpu_result_buffer: a queue model predicts every
// head entry, flag and occupancy output cycle by cycle.
module tb_fpu_result_buffer;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, fpu_valid_i, fpu_is_fp32_i, wb_ready_i, clear_fflags_i;
  logic [63:0] fpu_result_i, wb_result_o;
  logic [4:0]  fpu_status_i, wb_status_o, fflags_o;
  logic [3:0]  fpu_tag_i, wb_tag_o;
  logic        almost_full_o, wb_valid_o, overflow_o;

  fpu_result_buffer #(
    .WIDTH(64), .DEPTH(DEPTH), .AF_LEVEL(AF), .TagType(logic [3:0])
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fpu_valid_i(fpu_valid_i), .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fpu_tag_i(fpu_tag_i), .fpu_is_fp32_i(fpu_is_fp32_i), .almost_full_o(almost_full_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
    .wb_status_o(wb_status_o), .wb_tag_o(wb_tag_o), .fflags_o(fflags_o),
    .clear_fflags_i(clear_fflags_i), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  st;
    logic [3:0]  tag;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] m_fflags;
  logic       m_ovf;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, compare the current outputs with the model,
  // then advance the model exactly as the buffer should behave at the edge.
  task automatic cyc(input logic v, input logic [63:0] r, input logic [4:0] s,
                     input logic [3:0] t, input logic f32, input logic rdy,
                     input logic fl, input logic clr);
    exp_t e;
    exp_t h;
    logic popm, fullm;
    fpu_valid_i = v; fpu_result_i = r; fpu_status_i = s; fpu_tag_i = t;
    fpu_is_fp32_i = f32; wb_ready_i = rdy; flush_i = fl; clear_fflags_i = clr;
    rst_i = 1'b0;
    #1;
    chk("valid", wb_valid_o, sb.size() != 0);
    chk("almost_full", almost_full_o, sb.size() >= AF);
    chk("fflags", fflags_o, m_fflags);
    chk("overflow", overflow_o, m_ovf);
    if (sb.size() != 0) begin
      chk("result", wb_result_o, sb[0].res);
      chk("status", wb_status_o, sb[0].st);
      chk("tag", wb_tag_o, sb[0].tag);
    end
    if (fl) begin
      sb.delete();
      if (clr) m_fflags = 5'b0;
    end else begin
      popm  = (sb.size() != 0) && rdy;
      fullm = (sb.size() == DEPTH);
      if (popm) begin
        h = sb.pop_front();
        m_fflags = (clr ? 5'b0 : m_fflags) | h.st;
      end else if (clr) m_fflags = 5'b0;
      if (v) begin
        if (fullm && !popm) m_ovf = 1'b1;
        else begin
          e.res = f32 ? {32'hFFFF_FFFF, r[31:0]} : r;
          e.st  = s;
          e.tag = t;
          sb.push_back(e);
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; fpu_valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
    clear_fflags_i = 1'b0; fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
    fpu_is_fp32_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.delete();
    m_fflags = 5'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, wb_valid_o, 1'b0);
    chk({tag, "_af"}, almost_full_o, 1'b0);
    chk({tag, "_result"}, wb_result_o, 64'h0);
    chk({tag, "_status"}, wb_status_o, 5'h0);
    chk({tag, "_tag"}, wb_tag_o, 4'h0);
    chk({tag, "_fflags"}, fflags_o, 5'h0);
    chk({tag, "_ovf"}, overflow_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_reset();
    chk_zero("reset");

    // 1: single result, one-cycle latency, fflags accrue NX on accept.
    cyc(1, 64'h3FF0_0000_0000_0000, 5'b00001, 4'd2, 0, 0, 0, 0);
    chk("t1_valid_next", wb_valid_o, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_fflags", fflags_o, 5'b00001);

    // 2: four results unaccepted, fifth overflows, then drain in order.
    for (int i = 0; i < 4; i++) cyc(1, 64'h100 + i, 5'b0, 4'(4 + i), 0, 0, 0, 0);
    cyc(1, 64'hDEAD, 5'b10000, 4'hF, 0, 0, 0, 0);
    chk("t2_overflow", overflow_o, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t2_empty", wb_valid_o, 1'b0);

    // 3: full queue, push with accept: no overflow growth, new tag last.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 64'h200 + i, 5'b00010, 4'(i), 0, 0, 0, 0);
    cyc(1, 64'h2FF, 5'b00100, 4'd9, 0, 1, 0, 0);
    chk("t3_no_ovf", overflow_o, 1'b0);
    chk("t3_af", almost_full_o, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // 4: FP32 result is NaN-boxed.
    cyc(1, 64'h0000_0000_3F80_0000, 5'b0, 4'd3, 1, 0, 0, 0);
    chk("t4_nanbox", wb_result_o, 64'hFFFF_FFFF_3F80_0000);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // 5: flush with a pulse and accept in the same cycle drops everything.
    for (int i = 0; i < 3; i++) cyc(1, 64'h300 + i, 5'b10000, 4'(i), 0, 0, 0, 0);
    cyc(1, 64'h3FF, 5'b01000, 4'd7, 0, 1, 1, 0);
    chk("t5_valid", wb_valid_o, 1'b0);
    chk("t5_fflags", fflags_o, 5'b00110);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // 6: clear in the accept cycle keeps the popped DZ.
    do_reset();
    cyc(1, 64'h400, 5'b10000, 4'd1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6_nv", fflags_o, 5'b10000);
    cyc(1, 64'h401, 5'b01000, 4'd2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    chk("t6_dz", fflags_o, 5'b01000);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 64'h500 + i, 5'b00001, 4'(i), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    chk_zero("midrst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
          4'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
